// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder front end
// Contents: state_t (driver FSM states), DEFAULT_N (default operand width),
//           CNT_W (bit counter width for DEFAULT_N), cnt_width() (counter width for any N).
package serial_add_pkg;

    localparam int DEFAULT_N = 8;
    localparam int CNT_W = $clog2(DEFAULT_N + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CAPT,
        DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// rtl/serial_add_if.sv - parallel load/result handshake bundle of serial_add_driver
// Signals: load_valid/load_ready, op_a, op_b, cin (operand request),
//          sum, cout_out, res_valid/res_ready (result).
// Modports: master = producer/consumer side, slave = serial_add_driver side.
interface serial_add_if import serial_add_pkg::*; #(
    parameter int N = DEFAULT_N
) ();

    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout_out;
    logic         res_valid;
    logic         res_ready;

    modport master (
        output load_valid, op_a, op_b, cin, res_ready,
        input  load_ready, sum, cout_out, res_valid
    );

    modport slave (
        input  load_valid, op_a, op_b, cin, res_ready,
        output load_ready, sum, cout_out, res_valid
    );

endinterface

// File: rtl/serial_shreg.sv
// rtl/serial_shreg.sv - W-bit loadable shift register with direction select
// Ports: clk, rst (sync, active-high), load/load_val (parallel load, wins over shift),
//        shift_en, dir_left (1 = shift toward MSB, 0 = toward LSB), ser_in,
//        q (parallel contents), ser_out (bit leaving in the selected direction).
module serial_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         dir_left,
    input  logic         ser_in,
    output logic [W-1:0] q,
    output logic         ser_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            if (dir_left) begin
                q <= {q[W-2:0], ser_in};
            end else begin
                q <= {ser_in, q[W-1:1]};
            end
        end
    end

    assign ser_out = dir_left ? q[W-1] : q[0];

endmodule

// File: rtl/serial_add_driver.sv
// rtl/serial_add_driver.sv - parallel front end for the bit-serial full adder
// Ports: CLK, rst (sync, active-high); bus (serial_add_if.slave: operand load and
//        result handshakes); ser_start, ser_rst, ser_a, ser_b, ser_cin (to adder);
//        ser_s, ser_cout (from adder); err (only with SERIAL_ADD_CHECK_EN).
// Optional: SERIAL_ADD_CHECK_EN adds a parallel reference adder and a sticky err flag.
module serial_add_driver import serial_add_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic      CLK,
    input  logic      rst,
    serial_add_if.slave bus,
    output logic      ser_start,
    output logic      ser_rst,
    output logic      ser_a,
    output logic      ser_b,
    output logic      ser_cin,
    input  logic      ser_s,
    input  logic      ser_cout
`ifdef SERIAL_ADD_CHECK_EN
    ,
    output logic      err
`endif
);

    localparam int CW = cnt_width(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load_ready_q;
    logic          res_valid_q;
    logic          cout_q;
    logic          accept;
    logic          sum_shift;
    logic [N-1:0]  sum_q;
    logic [N-1:0]  a_par_unused;
    logic [N-1:0]  b_par_unused;
    logic          sum_ser_unused;

    // load_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept = load_ready_q && bus.load_valid;

    // The adder answers one cycle late: the first SHIFT cycle has no sum bit yet,
    // and the last bit arrives during CAPT.
    assign sum_shift = ((state == SHIFT) && (cnt != '0)) || (state == CAPT);

    serial_shreg #(.W(N)) u_a_sh (
        .clk      (CLK),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.op_a),
        .shift_en (state == SHIFT),
        .dir_left (1'b0),
        .ser_in   (1'b0),
        .q        (a_par_unused),
        .ser_out  (ser_a)
    );

    serial_shreg #(.W(N)) u_b_sh (
        .clk      (CLK),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.op_b),
        .shift_en (state == SHIFT),
        .dir_left (1'b0),
        .ser_in   (1'b0),
        .q        (b_par_unused),
        .ser_out  (ser_b)
    );

    // Sum bits enter at the MSB; after N shifts bit 0 has reached the LSB.
    serial_shreg #(.W(N)) u_sum_sh (
        .clk      (CLK),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (sum_shift),
        .dir_left (1'b0),
        .ser_in   (ser_s),
        .q        (sum_q),
        .ser_out  (sum_ser_unused)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            load_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
            ser_start    <= 1'b0;
            ser_rst      <= 1'b0;
            ser_cin      <= 1'b0;
            cout_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= CLEAR;
                        load_ready_q <= 1'b0;
                        ser_rst      <= 1'b1;
                        ser_cin      <= bus.cin;
                        cnt          <= '0;
                    end
                end
                CLEAR: begin
                    ser_rst   <= 1'b0;
                    ser_start <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CW'(N - 1)) begin
                        ser_start <= 1'b0;
                        state     <= CAPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPT: begin
                    cout_q      <= ser_cout;
                    res_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q  <= 1'b0;
                        load_ready_q <= 1'b1;
                        ser_cin      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.sum        = sum_q;
    assign bus.cout_out   = cout_q;

`ifdef SERIAL_ADD_CHECK_EN
    logic [N-1:0] chk_a;
    logic [N-1:0] chk_b;
    logic [N:0]   chk_sum;
    logic [N:0]   ser_result;

    assign chk_sum    = {1'b0, chk_a} + {1'b0, chk_b} + {{N{1'b0}}, ser_cin};
    // What {cout_out, sum} will hold once the CAPT edge has taken the last bit.
    assign ser_result = {ser_cout, ser_s, sum_q[N-1:1]};

    always_ff @(posedge CLK) begin
        if (rst) begin
            chk_a <= '0;
            chk_b <= '0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                chk_a <= bus.op_a;
                chk_b <= bus.op_b;
            end
            if ((state == CAPT) && (chk_sum != ser_result)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_driver.sv
// tb/tb_serial_add_driver.sv - scoreboard bench for serial_add_driver with a serial adder model
module tb_serial_add_driver;
    import serial_add_pkg::*;

    localparam int N = 8;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    serial_add_if #(.N(N)) bus ();

    logic ser_start, ser_rst, ser_a, ser_b, ser_cin, ser_s, ser_cout;
`ifdef SERIAL_ADD_CHECK_EN
    logic err;
`endif

    serial_add_driver #(.N(N)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .bus       (bus),
        .ser_start (ser_start),
        .ser_rst   (ser_rst),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_cin   (ser_cin),
        .ser_s     (ser_s),
        .ser_cout  (ser_cout)
`ifdef SERIAL_ADD_CHECK_EN
        ,
        .err       (err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rr_mode = 0;
    bit corrupt = 1'b0;

    logic [N:0] exp_q[$];
    int         t0_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial full adder with one cycle of latency; can flip sum bit 3 on demand.
    logic m_c = 1'b0;
    logic m_s = 1'b0;
    int   m_bit = 0;
    always @(posedge CLK) begin
        if (rst) begin
            m_c   <= 1'b0;
            m_s   <= 1'b0;
            m_bit <= 0;
        end else if (ser_rst) begin
            m_c   <= ser_cin;
            m_s   <= 1'b0;
            m_bit <= 0;
        end else if (ser_start) begin
            m_s   <= ser_a ^ ser_b ^ m_c ^ (corrupt && (m_bit == 3));
            m_c   <= (ser_a & ser_b) | (ser_a & m_c) | (ser_b & m_c);
            m_bit <= m_bit + 1;
        end
    end
    assign ser_s    = m_s;
    assign ser_cout = m_c;

    always @(posedge CLK) begin
        #1;
        if (rr_mode == 1) bus.res_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: latency on every rising res_valid, result on every handshake.
    logic prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.res_valid && !prev_valid) begin
                    if (t0_q.size() == 0) begin
                        chk("unexpected_res_valid", 1, 0);
                    end else begin
                        int t0;
                        t0 = t0_q.pop_front();
                        chk("latency", cyc - t0, N + 3);
                    end
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        logic [N:0] e;
                        e = exp_q.pop_front();
                        chk("result", {bus.cout_out, bus.sum}, e);
                    end
                end
                prev_valid = bus.res_valid;
            end
        end
    end

    task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic [N:0] xmask, output int t0);
        int k;
        @(negedge CLK);
        k = 0;
        while (!bus.load_ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (!bus.load_ready) begin
            chk("load_ready_timeout", 0, 1);
            t0 = -1;
            return;
        end
        bus.op_a       = a;
        bus.op_b       = b;
        bus.cin        = c;
        bus.load_valid = 1'b1;
        t0 = cyc;
        exp_q.push_back(({1'b0, a} + {1'b0, b} + {{N{1'b0}}, c}) ^ xmask);
        t0_q.push_back(cyc);
        @(posedge CLK);
        #1;
        bus.load_valid = 1'b0;
        bus.op_a       = N'($urandom);
        bus.op_b       = N'($urandom);
        bus.cin        = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, bad_hold, bad_ready, bad_valid, k;
        logic [N:0] bp_exp;

        bus.load_valid = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.cin        = 1'b0;
        bus.res_ready  = 1'b1;
        rst            = 1'b1;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_ser_start", ser_start, 0);
        chk("rst_ser_rst", ser_rst, 0);
        chk("rst_ser_a", ser_a, 0);
        chk("rst_ser_b", ser_b, 0);
        chk("rst_ser_cin", ser_cin, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout_out, 0);
`ifdef SERIAL_ADD_CHECK_EN
        chk("rst_err", err, 0);
`endif
        rst = 1'b0;
        @(negedge CLK);
        chk("idle_load_ready", bus.load_ready, 1);

        // Basic add and carry cases, back to back with res_ready high
        do_load(8'h35, 8'h4A, 1'b0, '0, t1);
        drain("drain_basic");
        do_load(8'hFF, 8'h01, 1'b0, '0, t1);
        do_load(8'hFF, 8'hFF, 1'b1, '0, t2);
        chk("accept_spacing", t2 - t1, N + 4);
        drain("drain_carry");

        // Backpressure: result must hold while res_ready is low
        bus.res_ready = 1'b0;
        do_load(8'hA5, 8'h3C, 1'b1, '0, t1);
        bp_exp = {1'b0, 8'hA5} + {1'b0, 8'h3C} + 9'd1;
        k = 0;
        while (!bus.res_valid && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("bp_res_valid_seen", bus.res_valid, 1);
        bad_hold = 0;
        bad_ready = 0;
        bad_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            bus.load_valid = 1'b1;
            bus.op_a = N'($urandom);
            bus.op_b = N'($urandom);
            if ({bus.cout_out, bus.sum} != bp_exp) bad_hold++;
            if (bus.load_ready) bad_ready++;
            if (!bus.res_valid) bad_valid++;
        end
        chk("bp_hold_result", bad_hold, 0);
        chk("bp_load_ready_low", bad_ready, 0);
        chk("bp_res_valid_held", bad_valid, 0);
        @(negedge CLK);
        bus.load_valid = 1'b0;
        bus.res_ready  = 1'b1;
        @(negedge CLK);
        bus.res_ready  = 1'b0;
        chk("bp_release_load_ready", bus.load_ready, 1);
        chk("bp_release_res_valid", bus.res_valid, 0);
        bus.res_ready  = 1'b1;
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset during the 4th SHIFT cycle
        do_load(8'h77, 8'h11, 1'b0, '0, t1);
        repeat (5) @(negedge CLK);
        chk("mid_shift_active", ser_start, 1);
        rst = 1'b1;
        @(negedge CLK);
        chk("mid_rst_ser_start", ser_start, 0);
        chk("mid_rst_load_ready", bus.load_ready, 1);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_ser_cin", ser_cin, 0);
        exp_q.delete();
        t0_q.delete();
        rst = 1'b0;
        bad_valid = 0;
        for (int i = 0; i < N + 6; i++) begin
            @(negedge CLK);
            if (bus.res_valid) bad_valid++;
        end
        chk("mid_rst_no_result", bad_valid, 0);
        do_load(8'h12, 8'h34, 1'b0, '0, t1);
        drain("drain_after_rst");

`ifdef SERIAL_ADD_CHECK_EN
        chk("err_clean_so_far", err, 0);
        corrupt = 1'b1;
        do_load(8'h0F, 8'h01, 1'b0, 9'h008, t1);
        drain("drain_corrupt");
        corrupt = 1'b0;
        chk("err_set", err, 1);
        do_load(8'h21, 8'h43, 1'b0, '0, t1);
        drain("drain_post_corrupt");
        chk("err_sticky", err, 1);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        chk("err_cleared_by_rst", err, 0);
        rst = 1'b0;
        @(negedge CLK);
`endif

        // Randomized traffic with random backpressure
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            do_load(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), '0, t1);
        end
        drain("drain_random");
        rr_mode = 0;
        @(posedge CLK);
        #2;
        bus.res_ready = 1'b1;
        @(negedge CLK);
        chk("final_latency_queue", t0_q.size(), 0);
`ifdef SERIAL_ADD_CHECK_EN
        chk("final_err", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
